osc_capture_engine: RTL

Parametrised multi-channel trigger and capture core for the oscilloscope datapath, the next generation of the single-channel slope/level trigger. It sits between the ADC sample stream and the VGA waveform renderer. It decimates incoming samples by a selectable power of two and stores NCH channels in circular buffers with a pre-trigger window. Triggering uses a selectable channel, level and slope, in auto, normal or single mode. The renderer then reads one frozen frame through a registered read port.

---
 rtl/osc_capture_engine_if.sv | 38 +++
 rtl/osc_capture_engine.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/osc_capture_engine_if.sv
// Sample-stream, trigger-setup and frame-read bundle between the ADC front end,
// the capture engine and the waveform renderer.
interface osc_capture_engine_if #(
    parameter int NCH = 2,
    parameter int DW  = 8,
    parameter int AW  = 9
);
    localparam int SW = (NCH > 1) ? $clog2(NCH) : 1;

    logic              sample_valid;
    logic [NCH*DW-1:0] sample_data;
    logic [SW-1:0]     trig_sel;
    logic [DW-1:0]     trig_level;
    logic              slope;
    logic [1:0]        mode;
    logic              arm;
    logic [3:0]        decim;
    logic              frame_ack;
    logic [SW-1:0]     rd_ch;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              frame_ready;
    logic              busy;
    logic              auto_trig;
    logic [2:0]        state;

    modport master (
        output sample_valid, sample_data, trig_sel, trig_level, slope, mode, arm,
               decim, frame_ack, rd_ch, rd_addr,
        input  rd_data, frame_ready, busy, auto_trig, state
    );

    modport slave (
        input  sample_valid, sample_data, trig_sel, trig_level, slope, mode, arm,
               decim, frame_ack, rd_ch, rd_addr,
        output rd_data, frame_ready, busy, auto_trig, state
    );
endinterface

// File: rtl/osc_capture_engine.sv
// Multi-channel decimating capture with pre-trigger window, level/slope trigger
// (auto/normal/single) and a registered read port over the frozen frame.
module osc_capture_engine #(
    parameter int NCH     = 2,
    parameter int DW      = 8,
    parameter int AW      = 9,
    parameter int PRE     = 128,
    parameter int AUTO_TO = 1000000
) (
    input logic                clk,
    input logic                rst,
    osc_capture_engine_if.slave bus
);
    localparam int DEPTH = 1 << AW;
    localparam int SW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW    = $clog2(AUTO_TO + 1);
    localparam int CW    = AW + 1;

    typedef enum logic [2:0] {
        IDLE = 3'd0, PREFILL = 3'd1, WAIT_TRIG = 3'd2, POSTFILL = 3'd3, DONE = 3'd4
    } state_t;

    state_t         st;
    logic [AW-1:0]  wr_ptr, trig_ptr, rd_idx;
    logic [CW-1:0]  fill_cnt;
    logic [14:0]    dcnt, dmask;
    logic [3:0]     decim_q;
    logic [SW-1:0]  tsel_q, rsel;
    logic [DW-1:0]  level_q, prev, cur, rd_q;
    logic           slope_q, prev_vld;
    logic [TW-1:0]  to_cnt;
    logic           frame_ready_q, busy_q, auto_trig_q;
    logic           capturing, accept, crossed, forced, go_prefill;
    logic           mode_auto, mode_single;
    logic [NCH-1:0][DW-1:0] ch_rd;

    assign mode_auto   = (bus.mode == 2'b00);
    assign mode_single = (bus.mode == 2'b10);
    assign capturing   = (st == PREFILL) || (st == WAIT_TRIG) || (st == POSTFILL);
    assign accept      = bus.sample_valid && capturing && (dcnt == '0);
    // 1<<15 wraps to 0 in 15 bits, so decim=15 still yields an all-ones mask
    assign dmask       = (15'd1 << decim_q) - 15'd1;
    assign cur         = bus.sample_data[tsel_q*DW +: DW];
    assign crossed     = prev_vld && (slope_q ? (prev < level_q && cur >= level_q)
                                              : (prev > level_q && cur <= level_q));
    assign forced      = mode_auto && (to_cnt == TW'(AUTO_TO));
    assign go_prefill  = ((st == IDLE) && (!mode_single || bus.arm)) ||
                         ((st == DONE) && bus.frame_ack && !mode_single);

    always_ff @(posedge clk) begin
        if (!rst) begin
            st            <= IDLE;
            wr_ptr        <= '0;
            trig_ptr      <= '0;
            fill_cnt      <= '0;
            dcnt          <= '0;
            decim_q       <= '0;
            tsel_q        <= '0;
            level_q       <= '0;
            slope_q       <= 1'b0;
            prev          <= '0;
            prev_vld      <= 1'b0;
            to_cnt        <= '0;
            frame_ready_q <= 1'b0;
            busy_q        <= 1'b0;
            auto_trig_q   <= 1'b0;
        end else begin
            if (accept)
                wr_ptr <= wr_ptr + 1'b1;
            if (bus.sample_valid && capturing)
                dcnt <= (dcnt == dmask) ? '0 : dcnt + 15'd1;

            if (go_prefill) begin
                // capture setup is frozen here for the whole frame
                st            <= PREFILL;
                decim_q       <= bus.decim;
                tsel_q        <= (int'(bus.trig_sel) >= NCH) ? '0 : bus.trig_sel;
                level_q       <= bus.trig_level;
                slope_q       <= bus.slope;
                dcnt          <= '0;
                fill_cnt      <= '0;
                prev_vld      <= 1'b0;
                busy_q        <= 1'b1;
                frame_ready_q <= 1'b0;
            end else begin
                case (st)
                    PREFILL: if (accept) begin
                        prev     <= cur;
                        prev_vld <= 1'b1;
                        if (fill_cnt == CW'(PRE - 1)) begin
                            st       <= WAIT_TRIG;
                            fill_cnt <= '0;
                            to_cnt   <= '0;
                        end else
                            fill_cnt <= fill_cnt + 1'b1;
                    end
                    WAIT_TRIG: begin
                        if (to_cnt != TW'(AUTO_TO))
                            to_cnt <= to_cnt + 1'b1;
                        if (accept) begin
                            prev     <= cur;
                            prev_vld <= 1'b1;
                            // a genuine crossing wins over the timeout
                            if (crossed || forced) begin
                                trig_ptr    <= wr_ptr;
                                auto_trig_q <= !crossed;
                                st          <= POSTFILL;
                                fill_cnt    <= '0;
                            end
                        end
                    end
                    POSTFILL: if (accept) begin
                        if (fill_cnt == CW'(DEPTH - PRE - 2)) begin
                            st            <= DONE;
                            busy_q        <= 1'b0;
                            frame_ready_q <= 1'b1;
                        end else
                            fill_cnt <= fill_cnt + 1'b1;
                    end
                    DONE: if (bus.frame_ack && mode_single) begin
                        st            <= IDLE;
                        frame_ready_q <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // logical index 0 is the oldest sample, PRE samples before the trigger
    assign rd_idx = trig_ptr - AW'(PRE) + bus.rd_addr;
    assign rsel   = (int'(bus.rd_ch) >= NCH) ? '0 : bus.rd_ch;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic [DW-1:0] mem [DEPTH];
        always_ff @(posedge clk)
            if (accept)
                mem[wr_ptr] <= bus.sample_data[k*DW +: DW];
        assign ch_rd[k] = mem[rd_idx];
    end

    always_ff @(posedge clk) begin
        if (!rst) rd_q <= '0;
        else      rd_q <= ch_rd[rsel];
    end

    assign bus.rd_data     = rd_q;
    assign bus.frame_ready = frame_ready_q;
    assign bus.busy        = busy_q;
    assign bus.auto_trig   = auto_trig_q;
    assign bus.state       = st;
endmodule
